// File: rtl/dmac_channel_arbiter_if.sv
// dmac_channel_arbiter_if
//   Signal bundle between the DMAC channel arbiter and its surroundings
//   (peripheral request lines, AHB bus arbiter, per-channel engines).
//   Modports:
//     slave  - the arbiter: takes requests/grant/channel status, drives
//              bus_req, ch_en, req_ack, cur_ch, busy, irq, irq_err, timeout_err
//     master - the environment driving the arbiter
//   Parameter NUM_CH sets the request/enable vector width.
interface dmac_channel_arbiter_if #(
  parameter int NUM_CH = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic [NUM_CH-1:0] dmac_req;
  logic              bus_grant;
  logic              ch_cfg_done;
  logic              ch_done;
  logic              ch_err;

  logic              bus_req;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] req_ack;
  logic [CW-1:0]     cur_ch;
  logic              busy;
  logic              irq;
  logic              irq_err;
  logic              timeout_err;

  modport slave (
    input  dmac_req, bus_grant, ch_cfg_done, ch_done, ch_err,
    output bus_req, ch_en, req_ack, cur_ch, busy, irq, irq_err, timeout_err
  );

  modport master (
    output dmac_req, bus_grant, ch_cfg_done, ch_done, ch_err,
    input  bus_req, ch_en, req_ack, cur_ch, busy, irq, irq_err, timeout_err
  );
endinterface

// File: rtl/dmac_channel_arbiter.sv
// dmac_channel_arbiter
//   Round-robin arbiter/sequencer for the DMAC channel engines. Picks one
//   requesting peripheral, holds the AHB bus request until grant and channel
//   configuration arrive, enables exactly one channel engine, and signals
//   completion or error with a one-cycle interrupt.
//
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-high reset
//     bus  - dmac_channel_arbiter_if.slave
//            in : dmac_req[NUM_CH], bus_grant, ch_cfg_done, ch_done, ch_err
//            out: bus_req, ch_en[NUM_CH], req_ack[NUM_CH], cur_ch, busy,
//                 irq, irq_err, timeout_err   (all registered)
//
//   Optional feature macro: DMAC_ARB_TIMEOUT_EN
//     Defined  : REQ_BUS gives up after GRANT_TIMEOUT cycles, reporting
//                irq + irq_err + timeout_err and advancing the round-robin
//                pointer so a stalled channel cannot starve the others.
//     Undefined: REQ_BUS waits indefinitely, timeout_err is tied low.
//
//   state   | meaning
//   IDLE    | no transfer, scanning dmac_req from rr_ptr
//   REQ_BUS | channel selected, bus_req held, waiting for grant + config
//   ACTIVE  | channel engine enabled while bus_grant is present
//   DONE    | one-cycle completion, irq pulse, rr_ptr advances
module dmac_channel_arbiter #(
  parameter int NUM_CH        = 4,
  parameter int GRANT_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  dmac_channel_arbiter_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ_BUS = 2'd1;
  localparam logic [1:0] S_ACTIVE  = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [CW-1:0]     r_rr_ptr;
  logic [CW-1:0]     r_cur_ch;
  logic              r_bus_req;
  logic [NUM_CH-1:0] r_ch_en;
  logic [NUM_CH-1:0] r_req_ack;
  logic              r_busy;
  logic              r_irq;
  logic              r_irq_err;
  logic              r_timeout_err;

  logic [CW-1:0]     w_sel;
  logic              w_any_req;
  logic [CW:0]       w_idx;
  logic [NUM_CH-1:0] w_cur_oh;
  logic [CW-1:0]     w_next_ptr;

  // First set request scanning upward from rr_ptr with wrap. The index is
  // one bit wider than cur_ch so rr_ptr + i never overflows before the wrap.
  always_comb begin
    w_sel     = '0;
    w_any_req = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (CW+1)'(i);
      if (w_idx >= (CW+1)'(NUM_CH)) begin
        w_idx = w_idx - (CW+1)'(NUM_CH);
      end
      if (!w_any_req && bus.dmac_req[w_idx[CW-1:0]]) begin
        w_any_req = 1'b1;
        w_sel     = w_idx[CW-1:0];
      end
    end
  end

  assign w_cur_oh   = {{(NUM_CH-1){1'b0}}, 1'b1} << r_cur_ch;
  assign w_next_ptr = (r_cur_ch == CW'(NUM_CH-1)) ? '0 : r_cur_ch + CW'(1);

`ifdef DMAC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(GRANT_TIMEOUT+1);
  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TW'(GRANT_TIMEOUT-1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (GRANT_TIMEOUT == 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_cur_ch      <= '0;
      r_bus_req     <= 1'b0;
      r_ch_en       <= '0;
      r_req_ack     <= '0;
      r_busy        <= 1'b0;
      r_irq         <= 1'b0;
      r_irq_err     <= 1'b0;
      r_timeout_err <= 1'b0;
`ifdef DMAC_ARB_TIMEOUT_EN
      r_tmo_cnt     <= '0;
`endif
    end else begin
      r_req_ack     <= '0;
      r_irq         <= 1'b0;
      r_irq_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state   <= S_REQ_BUS;
            r_cur_ch  <= w_sel;
            r_bus_req <= 1'b1;
            r_busy    <= 1'b1;
`ifdef DMAC_ARB_TIMEOUT_EN
            r_tmo_cnt <= '0;
`endif
          end
        end
        S_REQ_BUS: begin
          // Withdrawal beats acceptance and timeout in the same cycle.
          if (!bus.dmac_req[r_cur_ch]) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
            r_busy    <= 1'b0;
          end else if (bus.bus_grant && bus.ch_cfg_done) begin
            r_state   <= S_ACTIVE;
            r_req_ack <= w_cur_oh;
            r_ch_en   <= w_cur_oh;
          end
`ifdef DMAC_ARB_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_state       <= S_DONE;
            r_bus_req     <= 1'b0;
            r_irq         <= 1'b1;
            r_irq_err     <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
`endif
        end
        S_ACTIVE: begin
          if (bus.ch_done || bus.ch_err) begin
            r_state   <= S_DONE;
            r_bus_req <= 1'b0;
            r_ch_en   <= '0;
            r_irq     <= 1'b1;
            r_irq_err <= bus.ch_err;
          end else begin
            // Grant loss pauses the engine but keeps the channel owned.
            r_ch_en <= bus.bus_grant ? w_cur_oh : '0;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_rr_ptr <= w_next_ptr;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_req     = r_bus_req;
  assign bus.ch_en       = r_ch_en;
  assign bus.req_ack     = r_req_ack;
  assign bus.cur_ch      = r_cur_ch;
  assign bus.busy        = r_busy;
  assign bus.irq         = r_irq;
  assign bus.irq_err     = r_irq_err;
  assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_dmac_channel_arbiter.sv
// tb_dmac_channel_arbiter
//   Self-checking bench for dmac_channel_arbiter (NUM_CH=4, GRANT_TIMEOUT=8).
//   A transaction-level model tracks the round-robin pointer and predicts
//   which channel each request pattern should select.
module tb_dmac_channel_arbiter;
  localparam int NUM_CH        = 4;
  localparam int GRANT_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   model_rr = 0;
  int   ack_cnt[NUM_CH];
  int   irq_cnt  = 0;

  always #5 clk = ~clk;

  dmac_channel_arbiter_if #(.NUM_CH(NUM_CH)) bus_if ();

  dmac_channel_arbiter #(
    .NUM_CH       (NUM_CH),
    .GRANT_TIMEOUT(GRANT_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Invariants and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      checks++;
      if ($countones(bus_if.ch_en) > 1) begin
        failures++;
        $display("FAIL ch_en_onehot: got %b want one-hot or zero", bus_if.ch_en);
      end
      checks++;
      if (bus_if.req_ack !== '0 && bus_if.irq === 1'b1) begin
        failures++;
        $display("FAIL ack_irq_overlap: req_ack=%b irq=%b want not both", bus_if.req_ack, bus_if.irq);
      end
`ifndef DMAC_ARB_TIMEOUT_EN
      checks++;
      if (bus_if.timeout_err !== 1'b0) begin
        failures++;
        $display("FAIL timeout_err_tied: got %b want 0", bus_if.timeout_err);
      end
`endif
      for (int i = 0; i < NUM_CH; i++) if (bus_if.req_ack[i] === 1'b1) ack_cnt[i]++;
      if (bus_if.irq === 1'b1) irq_cnt++;
    end
  end

  task automatic tick;
    @(negedge clk);
  endtask

  // Expected selection: walk channels in round-robin order from the pointer.
  function automatic int model_pick(input logic [NUM_CH-1:0] req);
    int order[$];
    for (int k = 0; k < NUM_CH; k++) order.push_back((model_rr + k) % NUM_CH);
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic wait_bus_req(output bit ok);
    int n = 0;
    while (bus_if.bus_req !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    ok = (bus_if.bus_req === 1'b1);
  endtask

  task automatic do_reset;
    bus_if.dmac_req    = '0;
    bus_if.bus_grant   = 1'b0;
    bus_if.ch_cfg_done = 1'b0;
    bus_if.ch_done     = 1'b0;
    bus_if.ch_err      = 1'b0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;
    model_rr = 0;
  endtask

  // One full transfer; checks selection, ack/enable timing and completion.
  task automatic run_xfer(input logic [NUM_CH-1:0] req, input bit hold, input int gwait,
                          input int act_len, input bit d, input bit e, output int served);
    int exp;
    bit ok;
    logic [NUM_CH-1:0] oh;
    exp = model_pick(req);
    oh  = NUM_CH'(1 << exp);
    served = -1;
    bus_if.dmac_req = req;
    wait_bus_req(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL xfer_bus_req: got %b want 1", bus_if.bus_req);
      bus_if.dmac_req = '0;
      return;
    end
    checks++;
    if (bus_if.cur_ch !== 2'(exp) || bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL xfer_select: cur_ch=%0d busy=%b want cur_ch=%0d busy=1", bus_if.cur_ch, bus_if.busy, exp);
    end
    repeat (gwait) tick;
    checks++;
    if (bus_if.req_ack !== '0 || bus_if.ch_en !== '0 || bus_if.bus_req !== 1'b1) begin
      failures++;
      $display("FAIL xfer_wait_grant: ack=%b en=%b bus_req=%b want 0000 0000 1", bus_if.req_ack, bus_if.ch_en, bus_if.bus_req);
    end
    bus_if.bus_grant   = 1'b1;
    bus_if.ch_cfg_done = 1'b1;
    tick;
    bus_if.ch_cfg_done = 1'b0;
    checks++;
    if (bus_if.req_ack !== oh || bus_if.ch_en !== oh || bus_if.irq !== 1'b0) begin
      failures++;
      $display("FAIL xfer_accept: ack=%b en=%b irq=%b want %b %b 0", bus_if.req_ack, bus_if.ch_en, bus_if.irq, oh, oh);
    end
    if (!hold) bus_if.dmac_req = NUM_CH'($urandom);
    repeat (act_len) begin
      tick;
      checks++;
      if (bus_if.req_ack !== '0 || bus_if.ch_en !== oh || bus_if.cur_ch !== 2'(exp) || bus_if.bus_req !== 1'b1) begin
        failures++;
        $display("FAIL xfer_active: ack=%b en=%b cur=%0d bus_req=%b want 0000 %b %0d 1", bus_if.req_ack, bus_if.ch_en, bus_if.cur_ch, bus_if.bus_req, oh, exp);
      end
    end
    bus_if.ch_done = d;
    bus_if.ch_err  = e;
    tick;
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_err !== e || bus_if.ch_en !== '0 || bus_if.bus_req !== 1'b0 || bus_if.busy !== 1'b1) begin
      failures++;
      $display("FAIL xfer_done: irq=%b irq_err=%b en=%b bus_req=%b busy=%b want 1 %b 0000 0 1", bus_if.irq, bus_if.irq_err, bus_if.ch_en, bus_if.bus_req, bus_if.busy, e);
    end
    bus_if.ch_done   = 1'b0;
    bus_if.ch_err    = 1'b0;
    bus_if.bus_grant = 1'b0;
    bus_if.dmac_req  = hold ? req : '0;
    tick;
    checks++;
    if (bus_if.irq !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.bus_req !== 1'b0) begin
      failures++;
      $display("FAIL xfer_idle: irq=%b busy=%b bus_req=%b want 0 0 0", bus_if.irq, bus_if.busy, bus_if.bus_req);
    end
    model_rr = (exp + 1) % NUM_CH;
    served = exp;
  endtask

  task automatic test_reset;
    int s;
    bit ok;
    do_reset;
    checks++;
    if ({bus_if.bus_req, bus_if.ch_en, bus_if.req_ack, bus_if.cur_ch, bus_if.busy, bus_if.irq, bus_if.irq_err, bus_if.timeout_err} !== '0) begin
      failures++;
      $display("FAIL reset_values: bus_req=%b en=%b ack=%b cur=%0d busy=%b irq=%b want all 0", bus_if.bus_req, bus_if.ch_en, bus_if.req_ack, bus_if.cur_ch, bus_if.busy, bus_if.irq);
    end
    run_xfer(4'b0010, 1'b0, 1, 1, 1'b1, 1'b0, s);
    bus_if.dmac_req = 4'b0100;
    wait_bus_req(ok);
    bus_if.bus_grant   = 1'b1;
    bus_if.ch_cfg_done = 1'b1;
    tick;
    checks++;
    if (!ok || bus_if.ch_en !== 4'b0100) begin
      failures++;
      $display("FAIL reset_pre_active: ch_en=%b want 0100", bus_if.ch_en);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus_if.ch_en !== '0 || bus_if.bus_req !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.cur_ch !== '0 || bus_if.irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_active: en=%b bus_req=%b busy=%b cur=%0d irq=%b want 0", bus_if.ch_en, bus_if.bus_req, bus_if.busy, bus_if.cur_ch, bus_if.irq);
    end
    bus_if.dmac_req    = '0;
    bus_if.bus_grant   = 1'b0;
    bus_if.ch_cfg_done = 1'b0;
    tick;
    rst = 1'b0;
    model_rr = 0;
    irq_cnt  = 0;
    repeat (3) tick;
    checks++;
    if (irq_cnt !== 0) begin
      failures++;
      $display("FAIL reset_no_irq: irq pulses=%0d want 0", irq_cnt);
    end
    run_xfer(4'b1111, 1'b0, 0, 1, 1'b1, 1'b0, s);
  endtask

  task automatic test_single;
    int s;
    do_reset;
    run_xfer(4'b0100, 1'b0, 3, 2, 1'b1, 1'b0, s);
    run_xfer(4'b1111, 1'b0, 0, 1, 1'b1, 1'b0, s);
  endtask

  task automatic test_round_robin;
    int s;
    do_reset;
    for (int i = 0; i < NUM_CH; i++) ack_cnt[i] = 0;
    for (int k = 0; k < 4; k++) run_xfer(4'b1111, 1'b1, $urandom_range(0, 2), 1, 1'b1, 1'b0, s);
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (ack_cnt[i] !== 1) begin
        failures++;
        $display("FAIL rr_ack_once: ch%0d acked %0d times want 1", i, ack_cnt[i]);
      end
    end
    run_xfer(4'b1111, 1'b1, 0, 1, 1'b1, 1'b0, s);
    checks++;
    if (ack_cnt[0] !== 2) begin
      failures++;
      $display("FAIL rr_wrap: ch0 acked %0d times want 2", ack_cnt[0]);
    end
    bus_if.dmac_req = '0;
  endtask

  task automatic test_withdraw;
    int s;
    bit ok;
    do_reset;
    run_xfer(4'b0001, 1'b0, 1, 1, 1'b1, 1'b0, s);
    bus_if.dmac_req = 4'b0010;
    wait_bus_req(ok);
    checks++;
    if (!ok || bus_if.cur_ch !== 2'd1) begin
      failures++;
      $display("FAIL wd_select: cur_ch=%0d bus_req=%b want 1 1", bus_if.cur_ch, bus_if.bus_req);
    end
    tick;
    irq_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) ack_cnt[i] = 0;
    bus_if.dmac_req    = '0;
    bus_if.bus_grant   = 1'b1;
    bus_if.ch_cfg_done = 1'b1;
    tick;
    bus_if.bus_grant   = 1'b0;
    bus_if.ch_cfg_done = 1'b0;
    checks++;
    if (bus_if.bus_req !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.ch_en !== '0) begin
      failures++;
      $display("FAIL wd_idle: bus_req=%b busy=%b en=%b want 0 0 0000", bus_if.bus_req, bus_if.busy, bus_if.ch_en);
    end
    repeat (3) tick;
    checks++;
    if (irq_cnt !== 0 || ack_cnt[1] !== 0) begin
      failures++;
      $display("FAIL wd_no_ack_irq: irq=%0d ack=%0d want 0 0", irq_cnt, ack_cnt[1]);
    end
    run_xfer(4'b1111, 1'b0, 0, 1, 1'b1, 1'b0, s);
  endtask

  task automatic test_pause;
    bit ok;
    int exp;
    exp = model_pick(4'b1000);
    bus_if.dmac_req = 4'b1000;
    wait_bus_req(ok);
    bus_if.bus_grant   = 1'b1;
    bus_if.ch_cfg_done = 1'b1;
    tick;
    bus_if.ch_cfg_done = 1'b0;
    checks++;
    if (!ok || bus_if.ch_en !== 4'b1000) begin
      failures++;
      $display("FAIL pause_start: en=%b want 1000", bus_if.ch_en);
    end
    bus_if.bus_grant = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++;
      if (bus_if.ch_en !== '0 || bus_if.busy !== 1'b1 || bus_if.bus_req !== 1'b1) begin
        failures++;
        $display("FAIL pause_hold: cycle %0d en=%b busy=%b bus_req=%b want 0000 1 1", k, bus_if.ch_en, bus_if.busy, bus_if.bus_req);
      end
    end
    bus_if.bus_grant = 1'b1;
    tick;
    checks++;
    if (bus_if.ch_en !== 4'b1000) begin
      failures++;
      $display("FAIL pause_resume: en=%b want 1000", bus_if.ch_en);
    end
    bus_if.ch_done = 1'b1;
    tick;
    bus_if.ch_done   = 1'b0;
    bus_if.bus_grant = 1'b0;
    bus_if.dmac_req  = '0;
    checks++;
    if (bus_if.irq !== 1'b1 || bus_if.irq_err !== 1'b0) begin
      failures++;
      $display("FAIL pause_done: irq=%b irq_err=%b want 1 0", bus_if.irq, bus_if.irq_err);
    end
    tick;
    model_rr = (exp + 1) % NUM_CH;
  endtask

  task automatic test_error_priority;
    int s;
    irq_cnt = 0;
    run_xfer(NUM_CH'($urandom_range(1, 15)), 1'b0, 1, 2, 1'b1, 1'b1, s);
    tick;
    checks++;
    if (irq_cnt !== 1) begin
      failures++;
      $display("FAIL err_single_irq: irq pulses=%0d want 1", irq_cnt);
    end
  endtask

  task automatic test_random;
    int s;
    int r;
    for (int k = 0; k < 20; k++) begin
      r = $urandom_range(1, 3);
      run_xfer(NUM_CH'($urandom_range(1, 15)), 1'b0, $urandom_range(0, 4), $urandom_range(1, 3),
               r[0], r[1], s);
    end
  endtask

`ifdef DMAC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int s;
    int cnt;
    int n;
    bit ok;
    do_reset;
    bus_if.dmac_req = 4'b0001;
    wait_bus_req(ok);
    cnt = 0;
    n   = 0;
    while (bus_if.bus_req === 1'b1 && bus_if.irq !== 1'b1 && n < 30) begin
      cnt++;
      tick;
      n++;
    end
    checks++;
    if (!ok || bus_if.irq !== 1'b1 || bus_if.irq_err !== 1'b1 || bus_if.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL tmo_pulse: irq=%b irq_err=%b timeout_err=%b want 1 1 1", bus_if.irq, bus_if.irq_err, bus_if.timeout_err);
    end
    checks++;
    if (cnt !== GRANT_TIMEOUT) begin
      failures++;
      $display("FAIL tmo_cycles: REQ_BUS cycles=%0d want %0d", cnt, GRANT_TIMEOUT);
    end
    bus_if.dmac_req = '0;
    tick;
    checks++;
    if (bus_if.timeout_err !== 1'b0 || bus_if.busy !== 1'b0) begin
      failures++;
      $display("FAIL tmo_one_cycle: timeout_err=%b busy=%b want 0 0", bus_if.timeout_err, bus_if.busy);
    end
    model_rr = 1;
    run_xfer(4'b0011, 1'b0, 1, 1, 1'b1, 1'b0, s);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_withdraw;
    test_pause;
    test_error_priority;
    test_random;
`ifdef DMAC_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
